bytebram_port: RTL
==================

Name: bytebram_port

Overview:
- Parametrised successor to the byte-serial boot ROM: a byte-organised block RAM behind a multi-byte word port.
- Reads assemble a word one byte per cycle; writes scatter strobed bytes one per cycle.
- A one-entry last-read cache gives single-cycle repeat reads.
- Sits between the CPU memory bus and an iCE40 BRAM, usable as boot ROM (READONLY=1) or as byte-addressable RAM.

Parameters:
NB, 4, bytes per word (1..8); data width is 8*NB.
WORDS, 256, word depth; storage is WORDS*NB bytes.
MEM_HEX, "", byte-per-line hex init file; empty string means no init.
READONLY, 0, 1 = wstrb ignored, every access is a read.
CACHE_EN, 1, 1 = enable the last-read word cache.
AW, clog2(WORDS), word address width (derived).

Ports:
clk  in  1  clock
resetn  in  1  synchronous active-low reset
valid  in  1  request; held by the master until ready
ready  out  1  one-cycle completion pulse
addr  in  AW  word address
wstrb  in  NB  byte strobes; nonzero = write
wdata  in  8*NB  write data; byte k is wdata[8k+7:8k]
rdata  out  8*NB  read data, valid while ready=1 after a read
busy  out  1  high while the FSM is not IDLE

Behaviour:
- Reset (resetn=0 at posedge):
  - ready=0, rdata=0, busy=0, state=IDLE, cache invalid.
  - Memory contents untouched.
  - Reset takes precedence over everything, including mid-access; a partial write leaves already-written bytes written.
- Storage:
  - Byte array mem[0:WORDS*NB-1].
  - Word w occupies bytes w*NB .. w*NB+NB-1; byte k of the word sits at w*NB+k (little-endian).
- States: IDLE, ACCESS, DONE.
- IDLE:
  - Accept when valid=1 and ready=0.
  - Latch ptr=addr*NB, cnt=0, op=write if (wstrb!=0 and READONLY=0) else read; latch wdata/wstrb.
  - Cache hit (CACHE_EN=1, read op, cache valid, addr==cache_addr): load rdata from cache and go to DONE. ready is high in the cycle after the accept edge (1-cycle latency).
  - Otherwise go to ACCESS.
- ACCESS: one byte per clock, cnt = 0..NB-1, ptr increments each cycle.
  - Read: rdata[8cnt+7:8cnt] <= mem[ptr].
  - Write: if wstrb[cnt], mem[ptr] <= wdata byte cnt; rdata holds its previous value.
  - After cnt=NB-1, go to DONE.
  - Miss latency: ready is high NB+1 cycles after the accept edge (5 for NB=4).
- DONE:
  - ready=1 for exactly one cycle, then IDLE; ready is never high two consecutive cycles.
  - On read completion: cache_addr=addr, cache_data=rdata, cache valid.
- Back-to-back: a request still held at IDLE in the cycle after ready is accepted as a new transaction.
- Abort: valid=0 while in ACCESS →
  - return to IDLE next edge, no ready pulse;
  - bytes already written stay written;
  - cache invalidated;
  - rdata content undefined until the next completed read.
- Cache coherence:
  - Any accepted write whose addr equals cache_addr invalidates the cache at the accept edge.
  - Writes to other words leave the cache valid.
- Strobes: wstrb all-zero is a read. With READONLY=1 every access is a read and memory is never modified.
- Address: addr is AW bits, so no out-of-range access is possible. ptr is clog2(WORDS*NB) bits and never wraps within a word.
- Inputs sampled only at accept; changes to addr/wdata/wstrb during ACCESS are ignored.

Test Plan:
1. NB=4, MEM_HEX bytes i=i&0xFF. Reset, read addr=1 → ready exactly 5 cycles after accept, rdata=0x07060504, single-cycle pulse, busy low after.
2. Write addr=2, wstrb=0b0101, wdata=0xAABBCCDD, then read addr=2 → rdata=0x0BBB09DD, i.e. bytes 0 and 2 updated, bytes 1 and 3 unchanged.
3. Read addr=1 twice back-to-back → second ready 1 cycle after accept, rdata=0x07060504. Then write addr=1 wstrb=0xF wdata=0x11223344 and read addr=1 → full 5-cycle miss, rdata=0x11223344.
4. Start write addr=3 wstrb=0xF wdata=0xDEADBEEF; drop valid after 2 ACCESS cycles → no ready pulse. Read addr=3 → 0x0F0EBEEF.
5. Drive resetn=0 during ACCESS of a read → next cycle ready=0, rdata=0, busy=0. A subsequent read of addr=0 misses (5 cycles) and returns 0x03020100.
6. READONLY=1: write addr=0 wstrb=0xF wdata=0xFFFFFFFF → completes as a read returning 0x03020100, memory unchanged on re-read.

Source files
------------

// File: rtl/bytebram_port.sv
// rtl/bytebram_port.sv - byte-organised block RAM behind a multi-byte word port
// Words are gathered/scattered one byte per clock; a one-entry cache serves repeat reads.
module bytebram_port #(
  parameter int    NB       = 4,
  parameter int    WORDS    = 256,
  parameter string MEM_HEX  = "",
  parameter bit    READONLY = 1'b0,
  parameter bit    CACHE_EN = 1'b1,
  parameter int    AW       = (WORDS > 1) ? $clog2(WORDS) : 1
) (
  input  logic            clk_i,
  input  logic            resetn_i,
  input  logic            valid_i,
  output logic            ready_o,
  input  logic [AW-1:0]   addr_i,
  input  logic [NB-1:0]   wstrb_i,
  input  logic [8*NB-1:0] wdata_i,
  output logic [8*NB-1:0] rdata_o,
  output logic            busy_o
);

  localparam int NBYTES = WORDS * NB;
  localparam int PW     = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam int CW     = (NB > 1) ? $clog2(NB) : 1;
  localparam int DW     = 8 * NB;
  localparam logic [CW-1:0] LAST = CW'(NB - 1);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_e;

  logic [7:0]    mem_q [0:NBYTES-1];

  state_e        state_q;
  logic [PW-1:0] ptr_q;
  logic [CW-1:0] cnt_q;
  logic          op_wr_q;
  logic [AW-1:0] addr_q;
  logic [NB-1:0] wstrb_q;
  logic [DW-1:0] wdata_q;
  logic [DW-1:0] rdata_q;
  logic          ready_q;
  logic          cache_vld_q;
  logic [AW-1:0] cache_addr_q;
  logic [DW-1:0] cache_data_q;

  logic          is_wr;
  logic          hit;

  assign is_wr = (wstrb_i != '0) && !READONLY;
  assign hit   = CACHE_EN && !is_wr && cache_vld_q && (addr_i == cache_addr_q);

  // Storage has no reset; a reset mid-write simply stops further byte writes.
  always_ff @(posedge clk_i) begin
    if (resetn_i && state_q == ACCESS && valid_i && op_wr_q && wstrb_q[cnt_q]) begin
      mem_q[ptr_q] <= wdata_q[8*cnt_q +: 8];
    end
  end

  always_ff @(posedge clk_i) begin
    if (!resetn_i) begin
      state_q     <= IDLE;
      ready_q     <= 1'b0;
      rdata_q     <= '0;
      cache_vld_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (valid_i && !ready_q) begin
            ptr_q   <= PW'(int'(addr_i) * NB);
            cnt_q   <= '0;
            addr_q  <= addr_i;
            wstrb_q <= wstrb_i;
            wdata_q <= wdata_i;
            op_wr_q <= is_wr;
            if (is_wr && addr_i == cache_addr_q) cache_vld_q <= 1'b0;
            if (hit) begin
              rdata_q <= cache_data_q;
              ready_q <= 1'b1;
              state_q <= DONE;
            end else begin
              state_q <= ACCESS;
            end
          end
        end
        ACCESS: begin
          if (!valid_i) begin
            // Master gave up: drop the access and distrust whatever rdata/cache hold.
            state_q     <= IDLE;
            cache_vld_q <= 1'b0;
          end else begin
            if (!op_wr_q) rdata_q[8*cnt_q +: 8] <= mem_q[ptr_q];
            ptr_q <= ptr_q + PW'(1);
            cnt_q <= cnt_q + CW'(1);
            if (cnt_q == LAST) begin
              ready_q <= 1'b1;
              state_q <= DONE;
            end
          end
        end
        DONE: begin
          ready_q <= 1'b0;
          state_q <= IDLE;
          if (!op_wr_q) begin
            cache_vld_q  <= 1'b1;
            cache_addr_q <= addr_q;
            cache_data_q <= rdata_q;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ready_o = ready_q;
  assign rdata_o = rdata_q;
  assign busy_o  = (state_q != IDLE);

endmodule
